// File: rtl/scr1_tb_imem_responder_pkg.sv
// Shared types and constants for the IMEM responder and other testbench-side stall injectors.
// The memif command/response encodings live here so the interface, responder and bench agree.
package scr1_tb_imem_responder_pkg;

    typedef enum logic {
        MEM_CMD_RD = 1'b0,
        MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        MEM_RESP_IDLE  = 2'b00,
        MEM_RESP_OKAY  = 2'b01,
        MEM_RESP_ERROR = 2'b10
    } type_scr1_mem_resp_e;

    localparam logic [31:0] RESP_BASE_ADDR_DFLT = 32'h0000_0200;

    // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR16_TAPS       = 16'h002D;
    localparam logic [15:0] LFSR16_STALL_MASK = 16'h0003;

    localparam int ERR_CAUSE_WRITE    = 0;
    localparam int ERR_CAUSE_MISALIGN = 1;
    localparam int ERR_CAUSE_BELOW    = 2;
    localparam int ERR_CAUSE_ABOVE    = 3;
    localparam int ERR_CAUSE_NUM      = 4;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {^(s & LFSR16_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/scr1_tb_imem_responder_if.sv
// IMEM request/response bundle between the core fetch unit (master) and memory (slave).
interface scr1_tb_imem_responder_if;
    import scr1_tb_imem_responder_pkg::*;

    logic                imem_req;
    type_scr1_mem_cmd_e  imem_cmd;
    logic [31:0]         imem_addr;
    logic                imem_req_ack;
    logic [31:0]         imem_rdata;
    type_scr1_mem_resp_e imem_resp;

    modport master (
        output imem_req, imem_cmd, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp
    );

    modport slave (
        input  imem_req, imem_cmd, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp
    );

endinterface

// File: rtl/scr1_tb_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shared by testbench stall injectors.
module scr1_tb_lfsr16
    import scr1_tb_imem_responder_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_state <= SEED;
        end else begin
            o_state <= lfsr16_next(o_state);
        end
    end

endmodule

// File: rtl/scr1_tb_imem_responder.sv
// IMEM memory-side responder: preloadable word array, fixed-latency response pipe,
// LFSR-driven request stalls and ERROR responses for illegal accesses.
module scr1_tb_imem_responder
    import scr1_tb_imem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = RESP_BASE_ADDR_DFLT,
    parameter int          LATENCY   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    scr1_tb_imem_responder_if.slave      imem,
    input  logic                         stall_en,
    input  logic                         ld_we,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [31:0]                  ld_data,
    output logic [31:0]                  rd_cnt,
    output logic [31:0]                  err_cnt
);

    localparam int          IDX_W    = $clog2(MEM_WORDS);
    localparam int          DEPTH    = (LATENCY < 1) ? 1 : LATENCY;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS * 4);

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("scr1_tb_imem_responder: LATENCY must be within 1..4");
    end

    logic [15:0]              w_lfsr;
    logic                     w_stall;
    logic                     w_accept;
    logic [ERR_CAUSE_NUM-1:0] w_err_cause;
    logic                     w_err;
    logic [IDX_W-1:0]         w_idx;

    logic [31:0]              r_mem [MEM_WORDS];
    logic [DEPTH-1:0]         r_vld;
    logic [DEPTH-1:0]         r_err;
    logic [31:0]              r_data [DEPTH];

    scr1_tb_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_state (w_lfsr)
    );

    assign w_stall           = stall_en & (&(w_lfsr | ~LFSR16_STALL_MASK));
    assign imem.imem_req_ack = ~w_stall;
    assign w_accept          = imem.imem_req & ~w_stall;

    always_comb begin
        w_err_cause                     = '0;
        w_err_cause[ERR_CAUSE_WRITE]    = (imem.imem_cmd == MEM_CMD_WR);
        w_err_cause[ERR_CAUSE_MISALIGN] = |imem.imem_addr[1:0];
        w_err_cause[ERR_CAUSE_BELOW]    = (imem.imem_addr < BASE_ADDR);
        w_err_cause[ERR_CAUSE_ABOVE]    = ({1'b0, imem.imem_addr} >= END_ADDR);
    end

    assign w_err = |w_err_cause;
    assign w_idx = IDX_W'((imem.imem_addr - BASE_ADDR) >> 2);

    // Array and pipe payload: nonblocking write gives read-before-write on a preload collision
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_addr] <= ld_data;
        end
        if (w_accept) begin
            r_err[0]  <= w_err;
            r_data[0] <= w_err ? 32'h0 : r_mem[w_idx];
        end
        for (int i = 1; i < DEPTH; i++) begin
            r_err[i]  <= r_err[i-1];
            r_data[i] <= r_data[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            rd_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (r_vld[DEPTH-1]) begin
                if (r_err[DEPTH-1]) begin
                    err_cnt <= err_cnt + 32'd1;
                end else begin
                    rd_cnt <= rd_cnt + 32'd1;
                end
            end
        end
    end

    // Last stage drives the bus; payload is masked so idle cycles read back as 0
    always_comb begin
        imem.imem_resp  = MEM_RESP_IDLE;
        imem.imem_rdata = 32'h0;
        if (r_vld[DEPTH-1]) begin
            imem.imem_resp  = r_err[DEPTH-1] ? MEM_RESP_ERROR : MEM_RESP_OKAY;
            imem.imem_rdata = r_data[DEPTH-1];
        end
    end

endmodule

// File: tb/tb_scr1_tb_imem_responder.sv
// Bench for scr1_tb_imem_responder: LATENCY 1, 2 and 3 instances share one stimulus stream,
// expected responses are queued per instance at accept and popped on their due cycle.
`timescale 1ns/1ps
module tb_scr1_tb_imem_responder;
    import scr1_tb_imem_responder_pkg::*;

    localparam int MW = 4096;
    localparam int IW = 12;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, req, cmd, stall_en, ld_we;
    logic [31:0]   addr, ld_data;
    logic [IW-1:0] ld_addr;

    logic          ack   [1:3];
    logic [1:0]    resp  [1:3];
    logic [31:0]   rdata [1:3];
    logic [31:0]   rdc   [1:3];
    logic [31:0]   erc   [1:3];

    exp_t          sb [1:3][$];
    logic [31:0]   mmem [int];
    logic [15:0]   mlfsr;
    int            cyc, n_acc, acc0, rd0;
    int            mrd [1:3];
    int            mer [1:3];
    int            nvec = 0;
    int            nerr = 0;

    always #5 clk = ~clk;

    for (genvar L = 1; L <= 3; L++) begin : g_dut
        scr1_tb_imem_responder_if u_if ();
        assign u_if.imem_req  = req;
        assign u_if.imem_cmd  = cmd ? MEM_CMD_WR : MEM_CMD_RD;
        assign u_if.imem_addr = addr;
        assign ack[L]   = u_if.imem_req_ack;
        assign resp[L]  = u_if.imem_resp;
        assign rdata[L] = u_if.imem_rdata;

        scr1_tb_imem_responder #(
            .MEM_WORDS (MW),
            .BASE_ADDR (32'h0000_0200),
            .LATENCY   (L),
            .LFSR_SEED (16'hACE1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .imem     (u_if.slave),
            .stall_en (stall_en),
            .ld_we    (ld_we),
            .ld_addr  (ld_addr),
            .ld_data  (ld_data),
            .rd_cnt   (rdc[L]),
            .err_cnt  (erc[L])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic mack();
        return !(stall_en && mlfsr[0] && mlfsr[1]);
    endfunction

    task automatic check();
        exp_t e;
        for (int L = 1; L <= 3; L++) begin
            chk($sformatf("ack_L%0d_c%0d", L, cyc), 32'(ack[L]), 32'(mack()));
            chk($sformatf("rd_cnt_L%0d_c%0d", L, cyc), rdc[L], 32'(mrd[L]));
            chk($sformatf("err_cnt_L%0d_c%0d", L, cyc), erc[L], 32'(mer[L]));
            if (sb[L].size() > 0 && sb[L][0].due == cyc) begin
                e = sb[L].pop_front();
                chk($sformatf("resp_L%0d_c%0d", L, cyc), 32'(resp[L]), e.err ? 32'd2 : 32'd1);
                chk($sformatf("rdata_L%0d_c%0d", L, cyc), rdata[L], e.data);
                if (e.err) mer[L]++;
                else       mrd[L]++;
            end else begin
                chk($sformatf("idle_resp_L%0d_c%0d", L, cyc), 32'(resp[L]), 32'd0);
                chk($sformatf("idle_rdata_L%0d_c%0d", L, cyc), rdata[L], 32'd0);
            end
        end
    endtask

    task automatic step();
        logic        macc, me;
        logic [31:0] md;
        exp_t        e;
        macc = req && mack();
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            if (macc) begin
                me = cmd || (addr[1:0] != 2'b00) || (addr < 32'h200) || (addr >= 32'h4200);
                md = me ? 32'h0 : mmem[int'((addr - 32'h200) >> 2)];
                n_acc++;
                for (int L = 1; L <= 3; L++) begin
                    e.err  = me;
                    e.data = md;
                    e.due  = cyc + L - 1;
                    sb[L].push_back(e);
                end
            end
            mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
        end
        if (ld_we) mmem[int'(ld_addr)] = ld_data;
        @(negedge clk);
        check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mlfsr = 16'hACE1;
        for (int L = 1; L <= 3; L++) begin
            sb[L].delete();
            mrd[L] = 0;
            mer[L] = 0;
            chk($sformatf("rst_resp_L%0d", L), 32'(resp[L]), 32'd0);
            chk($sformatf("rst_rdata_L%0d", L), rdata[L], 32'd0);
            chk($sformatf("rst_rd_cnt_L%0d", L), rdc[L], 32'd0);
            chk($sformatf("rst_err_cnt_L%0d", L), erc[L], 32'd0);
            chk($sformatf("rst_ack_L%0d", L), 32'(ack[L]), 32'(mack()));
        end
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = IW'(idx);
        ld_data = d;
        step();
        ld_we   = 1'b0;
    endtask

    task automatic issue(input logic c, input logic [31:0] a);
        req  = 1'b1;
        cmd  = c;
        addr = a;
        step();
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        cmd = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; cmd = 1'b0; addr = 32'h0; stall_en = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_data = 32'h0;
        cyc = 0; n_acc = 0;
        do_reset();

        // Preload under reset: the array itself is not reset
        load(0, 32'h0000_0033);
        load(1, 32'h0000_0001);
        load(2, 32'h2222_2222);
        load(3, 32'h3333_3333);
        load(MW - 1, 32'hCAFE_F00D);
        rst_n = 1'b1;
        idle(3);

        // Single read
        issue(1'b0, 32'h200);
        idle(5);
        chk("single_rd_cnt_L1", rdc[1], 32'd1);

        // Back-to-back reads
        issue(1'b0, 32'h200);
        issue(1'b0, 32'h204);
        issue(1'b0, 32'h208);
        issue(1'b0, 32'h20C);
        idle(5);

        // Illegal accesses plus the last legal word
        issue(1'b0, 32'h202);
        issue(1'b0, 32'h100);
        issue(1'b1, 32'h200);
        issue(1'b0, 32'h4200);
        issue(1'b0, 32'h1FC);
        issue(1'b0, 32'hFFFF_FFFC);
        issue(1'b0, 32'h41FC);
        idle(5);
        chk("err_total_L3", erc[3], 32'd6);
        chk("rd_total_L3", rdc[3], 32'd6);

        // Preload collision: same-cycle write and accept of idx 1
        ld_we = 1'b1; ld_addr = IW'(1); ld_data = 32'hDEAD_BEEF;
        issue(1'b0, 32'h204);
        ld_we = 1'b0;
        issue(1'b0, 32'h204);
        idle(5);

        // Random stalls with continuous requests
        acc0 = n_acc;
        rd0  = mrd[1];
        stall_en = 1'b1;
        req = 1'b1; cmd = 1'b0; addr = 32'h208;
        repeat (200) step();
        req = 1'b0;
        stall_en = 1'b0;
        idle(5);
        chk("stall_resp_vs_accepts", rdc[1] - 32'(rd0), 32'(n_acc - acc0));

        // Reset with requests in flight
        issue(1'b0, 32'h200);
        req = 1'b0;
        do_reset();
        idle(3);
        rst_n = 1'b1;
        idle(6);
        issue(1'b0, 32'h20C);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
